ss_uart_periph: RTL and testbench



---
 rtl/ss_uart_pkg.sv | 25 ++
 rtl/ss_uart_fifo.sv | 60 ++++++
 rtl/ss_uart_periph.sv | 319 +++++++++++++++++++++++++++++++
 tb/tb_ss_uart_periph.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/ss_uart_pkg.sv
// Shared constants and state encoding for the ss_uart_periph memory-mapped UART.
package ss_uart_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DIV    = 2'd2;

    localparam int ST_TX_FULL   = 0;
    localparam int ST_TX_IDLE   = 1;
    localparam int ST_RX_VALID  = 2;
    localparam int ST_RX_OVR    = 3;
    localparam int ST_TX_OVF    = 4;
    localparam int ST_FRAME_ERR = 5;
    localparam int ST_LPBK      = 6;

    localparam logic [15:0] MIN_DIV = 16'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/ss_uart_fifo.sv
// Synchronous FIFO for the UART TX path; a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module ss_uart_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push_s;
    logic             do_pop_s;

    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign empty_o   = (count_q == (AW+1)'(0));
    assign do_pop_s  = pop_i && !empty_o;
    assign do_push_s = push_i && (!full_o || do_pop_s);
    assign data_o    = mem_q[rd_ptr_q];

    // Storage array, written on accepted pushes only.
    always_ff @(posedge clk_i) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (do_push_s && !do_pop_s) begin
                count_q <= count_q + (AW+1)'(1);
            end else if (do_pop_s && !do_push_s) begin
                count_q <= count_q - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/ss_uart_periph.sv
// Memory-mapped 8N1 UART slave: TX FIFO plus serializer, synchronised RX deserializer.
// Define UART_LOOPBACK_EN to add STATUS.lpbk, which routes the TX stream into RX.
module ss_uart_periph
    import ss_uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR     = 32'h0200_0000,
    parameter logic [15:0] DEFAULT_DIV   = 16'd868,
    parameter int          TX_FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    output logic        uart_tx,
    input  logic        uart_rx
);

    logic        ready_q;
    logic [31:0] rdata_q;
    logic [15:0] div_q;
    logic [7:0]  rx_byte_q;
    logic        rx_valid_q;
    logic        rx_ovr_q;
    logic        tx_ovf_q;
    logic        frame_err_q;

    logic        hit_s, acc_s, wr_s, rd_s;
    logic [1:0]  off_s;
    logic        data_rd_s, push_req_s;
    logic        clr_ovr_s, clr_ovf_s, clr_ferr_s;
    logic [31:0] status_s, rd_mux_s;
    logic        lpbk_s, rx_src_s;
    logic        unused_s;

    uart_state_e tx_state_q;
    logic        tx_q;
    logic [15:0] tx_cnt_q, tx_div_q;
    logic [7:0]  tx_shift_q;
    logic [2:0]  tx_bit_q;
    logic        tx_last_s, tx_pop_s;
    logic [7:0]  fifo_dout_s;
    logic        fifo_full_s, fifo_empty_s;

    uart_state_e rx_state_q;
    logic        rx_meta_q, rx_sync_q, rx_prev_q;
    logic [15:0] rx_cnt_q, rx_div_q;
    logic [7:0]  rx_shift_q;
    logic [2:0]  rx_bit_q;
    logic        rx_done_q, rx_ferr_q;

    assign hit_s      = mem_valid && (mem_addr[31:4] == BASE_ADDR[31:4]);
    assign acc_s      = hit_s && !ready_q;
    assign off_s      = mem_addr[3:2];
    assign wr_s       = acc_s && mem_wstrb[0];
    assign rd_s       = acc_s && (mem_wstrb == 4'd0);
    assign data_rd_s  = rd_s && (off_s == REG_DATA);
    assign push_req_s = wr_s && (off_s == REG_DATA);
    assign clr_ovr_s  = wr_s && (off_s == REG_STATUS) && mem_wdata[ST_RX_OVR];
    assign clr_ovf_s  = wr_s && (off_s == REG_STATUS) && mem_wdata[ST_TX_OVF];
    assign clr_ferr_s = wr_s && (off_s == REG_STATUS) && mem_wdata[ST_FRAME_ERR];
    assign unused_s   = ^{mem_addr[1:0], mem_wdata[31:16]};

    assign mem_ready = ready_q;
    assign mem_rdata = rdata_q;

`ifdef UART_LOOPBACK_EN
    logic lpbk_q;

    // Loopback control bit in STATUS[6].
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lpbk_q <= 1'b0;
        end else if (wr_s && (off_s == REG_STATUS)) begin
            lpbk_q <= mem_wdata[ST_LPBK];
        end else begin
            lpbk_q <= lpbk_q;
        end
    end

    assign lpbk_s   = lpbk_q;
    assign rx_src_s = lpbk_q ? tx_q : uart_rx;
    assign uart_tx  = tx_q | lpbk_q;
`else
    assign lpbk_s   = 1'b0;
    assign rx_src_s = uart_rx;
    assign uart_tx  = tx_q;
`endif

    // STATUS register image.
    always_comb begin
        status_s               = 32'd0;
        status_s[ST_TX_FULL]   = fifo_full_s;
        status_s[ST_TX_IDLE]   = fifo_empty_s && (tx_state_q == IDLE);
        status_s[ST_RX_VALID]  = rx_valid_q;
        status_s[ST_RX_OVR]    = rx_ovr_q;
        status_s[ST_TX_OVF]    = tx_ovf_q;
        status_s[ST_FRAME_ERR] = frame_err_q;
        status_s[ST_LPBK]      = lpbk_s;
    end

    // Read data selection by register offset.
    always_comb begin
        rd_mux_s = 32'd0;
        case (off_s)
            REG_DATA:   rd_mux_s = {23'd0, rx_valid_q, rx_byte_q};
            REG_STATUS: rd_mux_s = status_s;
            REG_DIV:    rd_mux_s = {16'd0, div_q};
            default:    rd_mux_s = 32'd0;
        endcase
    end

    // Bus response plus control/status register updates.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_q     <= 1'b0;
            rdata_q     <= 32'd0;
            div_q       <= DEFAULT_DIV;
            rx_byte_q   <= 8'd0;
            rx_valid_q  <= 1'b0;
            rx_ovr_q    <= 1'b0;
            tx_ovf_q    <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            ready_q <= acc_s;
            rdata_q <= rd_s ? rd_mux_s : 32'd0;
            if (wr_s && (off_s == REG_DIV)) begin
                div_q <= (mem_wdata[15:0] < MIN_DIV) ? MIN_DIV : mem_wdata[15:0];
            end
            // A completing byte beats a concurrent DATA read.
            if (rx_done_q) begin
                rx_byte_q  <= rx_shift_q;
                rx_valid_q <= 1'b1;
            end else if (data_rd_s) begin
                rx_valid_q <= 1'b0;
            end
            if (rx_done_q && rx_valid_q && !data_rd_s) begin
                rx_ovr_q <= 1'b1;
            end else if (clr_ovr_s) begin
                rx_ovr_q <= 1'b0;
            end
            if (push_req_s && fifo_full_s && !tx_pop_s) begin
                tx_ovf_q <= 1'b1;
            end else if (clr_ovf_s) begin
                tx_ovf_q <= 1'b0;
            end
            if (rx_ferr_q) begin
                frame_err_q <= 1'b1;
            end else if (clr_ferr_s) begin
                frame_err_q <= 1'b0;
            end
        end
    end

    ss_uart_fifo #(
        .DEPTH (TX_FIFO_DEPTH),
        .WIDTH (8)
    ) u_tx_fifo (
        .clk_i   (clk),
        .rst_i   (reset),
        .push_i  (push_req_s),
        .data_i  (mem_wdata[7:0]),
        .pop_i   (tx_pop_s),
        .data_o  (fifo_dout_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

    assign tx_last_s = (tx_cnt_q == (tx_div_q - 16'd1));
    assign tx_pop_s  = !fifo_empty_s &&
                       ((tx_state_q == IDLE) || ((tx_state_q == STOP) && tx_last_s));

    // TX serializer; STOP chains directly into the next START when data waits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state_q <= IDLE;
            tx_q       <= 1'b1;
            tx_cnt_q   <= 16'd0;
            tx_div_q   <= DEFAULT_DIV;
            tx_shift_q <= 8'd0;
            tx_bit_q   <= 3'd0;
        end else begin
            case (tx_state_q)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (tx_pop_s) begin
                        tx_state_q <= START;
                        tx_q       <= 1'b0;
                        tx_cnt_q   <= 16'd0;
                        tx_div_q   <= div_q;
                        tx_shift_q <= fifo_dout_s;
                    end
                end
                START: begin
                    if (tx_last_s) begin
                        tx_state_q <= DATA;
                        tx_cnt_q   <= 16'd0;
                        tx_bit_q   <= 3'd0;
                        tx_q       <= tx_shift_q[0];
                        tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 16'd1;
                    end
                end
                DATA: begin
                    if (tx_last_s) begin
                        tx_cnt_q <= 16'd0;
                        if (tx_bit_q == 3'd7) begin
                            tx_state_q <= STOP;
                            tx_q       <= 1'b1;
                        end else begin
                            tx_bit_q   <= tx_bit_q + 3'd1;
                            tx_q       <= tx_shift_q[0];
                            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 16'd1;
                    end
                end
                STOP: begin
                    if (tx_last_s) begin
                        tx_cnt_q <= 16'd0;
                        if (tx_pop_s) begin
                            tx_state_q <= START;
                            tx_q       <= 1'b0;
                            tx_div_q   <= div_q;
                            tx_shift_q <= fifo_dout_s;
                        end else begin
                            tx_state_q <= IDLE;
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 16'd1;
                    end
                end
                default: begin
                    tx_state_q <= IDLE;
                    tx_q       <= 1'b1;
                end
            endcase
        end
    end

    // RX synchronizer and falling-edge history, all idle-high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_src_s;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // RX deserializer; emits one-cycle done / frame-error strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state_q <= IDLE;
            rx_cnt_q   <= 16'd0;
            rx_div_q   <= DEFAULT_DIV;
            rx_shift_q <= 8'd0;
            rx_bit_q   <= 3'd0;
            rx_done_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            rx_done_q <= 1'b0;
            rx_ferr_q <= 1'b0;
            case (rx_state_q)
                IDLE: begin
                    if (rx_prev_q && !rx_sync_q) begin
                        rx_state_q <= START;
                        rx_cnt_q   <= 16'd0;
                        rx_div_q   <= div_q;
                    end
                end
                START: begin
                    if (rx_cnt_q == ((rx_div_q >> 1) - 16'd1)) begin
                        rx_cnt_q   <= 16'd0;
                        rx_bit_q   <= 3'd0;
                        rx_state_q <= rx_sync_q ? IDLE : DATA;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 16'd1;
                    end
                end
                DATA: begin
                    if (rx_cnt_q == (rx_div_q - 16'd1)) begin
                        rx_cnt_q   <= 16'd0;
                        rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
                        if (rx_bit_q == 3'd7) begin
                            rx_state_q <= STOP;
                        end else begin
                            rx_bit_q <= rx_bit_q + 3'd1;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 16'd1;
                    end
                end
                STOP: begin
                    if (rx_cnt_q == (rx_div_q - 16'd1)) begin
                        rx_cnt_q   <= 16'd0;
                        rx_state_q <= IDLE;
                        rx_done_q  <= rx_sync_q;
                        rx_ferr_q  <= !rx_sync_q;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 16'd1;
                    end
                end
                default: begin
                    rx_state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ss_uart_periph.sv
// Directed self-checking bench for ss_uart_periph (default build, loopback macro undefined).
module tb_ss_uart_periph;

    localparam logic [31:0] A_DATA   = 32'h0200_0000;
    localparam logic [31:0] A_STATUS = 32'h0200_0004;
    localparam logic [31:0] A_DIV    = 32'h0200_0008;

    logic        clk;
    logic        reset;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        uart_tx;
    logic        uart_rx;

    int total;
    int bad;

    ss_uart_periph dut (
        .clk       (clk),
        .reset     (reset),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .uart_tx   (uart_tx),
        .uart_rx   (uart_rx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One idle cycle, then a request held until mem_ready (bounded); lat=-1 if never acked.
    task automatic bus(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                       output logic [31:0] rd, output int lat);
        cyc(1);
        mem_valid = 1'b1;
        mem_addr  = a;
        mem_wdata = wd;
        mem_wstrb = ws;
        lat = -1;
        rd  = 32'd0;
        for (int i = 1; i <= 8; i++) begin
            cyc(1);
            if (mem_ready === 1'b1) begin
                lat = i;
                rd  = mem_rdata;
                break;
            end
        end
        mem_valid = 1'b0;
        mem_wstrb = 4'd0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] rd;
        int lat;
        bus(a, d, 4'hF, rd, lat);
        chk("wr_ack_latency", lat, 32'd1);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] rd;
        int lat;
        bus(a, 32'd0, 4'd0, rd, lat);
        chk({tag, "_ack"}, lat, 32'd1);
        chk(tag, rd, exp);
    endtask

    // Decode one frame from uart_tx by centre sampling.
    task automatic tx_cap(input int div, output logic [7:0] b, output logic ok);
        ok = 1'b0;
        b  = 8'd0;
        for (int i = 0; i < 400; i++) begin
            cyc(1);
            if (uart_tx === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            cyc(div / 2);
            if (uart_tx !== 1'b0) ok = 1'b0;
            for (int k = 0; k < 8; k++) begin
                cyc(div);
                b[k] = uart_tx;
            end
            cyc(div);
            if (uart_tx !== 1'b1) ok = 1'b0;
        end
    endtask

    // Drive one 8N1 frame at 16 clocks per bit, then 8 idle-high cycles.
    task automatic rx_frame(input logic [7:0] b, input logic stopb);
        logic [9:0] f;
        f = {stopb, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rx = f[i];
            cyc(16);
        end
        uart_rx = 1'b1;
        cyc(8);
    endtask

    initial begin
        logic [9:0]  frame;
        logic [7:0]  cb;
        logic        cok;
        logic [31:0] rd;
        int          lat;

        total = 0;
        bad   = 0;
        clk = 1'b0;
        reset = 1'b1;
        mem_valid = 1'b0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        mem_wstrb = 4'd0;
        uart_rx   = 1'b1;
        cyc(3);
        reset = 1'b0;
        chk("rst_uart_tx", {31'd0, uart_tx}, 32'd1);
        chk("rst_ready", {31'd0, mem_ready}, 32'd0);
        chk("rst_rdata", mem_rdata, 32'd0);

        // Handshake: ack one cycle after valid, no second ack while valid lingers.
        cyc(1);
        mem_valid = 1'b1;
        mem_addr  = A_STATUS;
        mem_wstrb = 4'd0;
        cyc(1);
        chk("ack_one_cycle", {31'd0, mem_ready}, 32'd1);
        chk("rst_status", mem_rdata, 32'h2);
        cyc(1);
        chk("no_double_ack", {31'd0, mem_ready}, 32'd0);
        mem_valid = 1'b0;

        rd_chk("rst_div", A_DIV, 32'd868);
        wr(A_DIV, 32'd1);
        rd_chk("div_clamp", A_DIV, 32'd4);

        // TX 0xA5 at DIV=8, checked every cycle of the frame.
        wr(A_DIV, 32'd8);
        wr(A_DATA, 32'hA5);
        frame = {1'b1, 8'hA5, 1'b0};
        for (int k = 0; k < 80; k++) begin
            cyc(1);
            chk("tx_a5_bit", {31'd0, uart_tx}, {31'd0, frame[k / 8]});
        end
        cyc(2);
        rd_chk("tx_idle_after", A_STATUS, 32'h2);

        // FIFO fill and overflow at DIV=4, with concurrent frame capture.
        wr(A_DIV, 32'd4);
        fork
            begin
                for (int i = 1; i <= 5; i++) wr(A_DATA, 32'h11 * i);
                rd_chk("fifo_full_no_ovf", A_STATUS, 32'h1);
                wr(A_DATA, 32'h66);
                wr(A_DATA, 32'h77);
                rd_chk("tx_ovf_set", A_STATUS, 32'h11);
                wr(A_STATUS, 32'h10);
                rd_chk("tx_ovf_clear", A_STATUS, 32'h1);
            end
            begin
                for (int j = 1; j <= 5; j++) begin
                    tx_cap(4, cb, cok);
                    chk("tx_frame_ok", {31'd0, cok}, 32'd1);
                    chk("tx_fifo_byte", {24'd0, cb}, 32'h11 * j);
                end
            end
        join
        cyc(20);
        rd_chk("tx_drained", A_STATUS, 32'h2);

        // RX path at DIV=16.
        wr(A_DIV, 32'd16);
        rx_frame(8'h3C, 1'b1);
        rd_chk("rx_valid_status", A_STATUS, 32'h6);
        rd_chk("rx_data_first", A_DATA, 32'h13C);
        rd_chk("rx_data_second", A_DATA, 32'h03C);

        rx_frame(8'h5A, 1'b1);
        rx_frame(8'hC3, 1'b1);
        rd_chk("rx_ovr_status", A_STATUS, 32'hE);
        rd_chk("rx_ovr_data", A_DATA, 32'h1C3);
        rd_chk("rx_ovr_sticky", A_STATUS, 32'hA);
        wr(A_STATUS, 32'h08);
        rd_chk("rx_ovr_clear", A_STATUS, 32'h2);

        rx_frame(8'h81, 1'b1);
        rx_frame(8'h7E, 1'b0);
        rd_chk("frame_err_status", A_STATUS, 32'h26);
        rd_chk("frame_err_data", A_DATA, 32'h181);
        wr(A_STATUS, 32'h20);
        rd_chk("frame_err_clear", A_STATUS, 32'h2);

        // Short glitch must be rejected.
        uart_rx = 1'b0;
        cyc(3);
        uart_rx = 1'b1;
        cyc(40);
        rd_chk("glitch_status", A_STATUS, 32'h2);
        rd_chk("glitch_data", A_DATA, 32'h081);

        // Out-of-range address gets no response.
        bus(32'h0300_0000, 32'd0, 4'd0, rd, lat);
        chk("nohit_no_ready", lat, 32'hFFFF_FFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
